// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide unit: state encoding and defaults.
package div_pkg;

   localparam int unsigned DIV_DATA_W = 32;
   localparam int unsigned DIV_CNT_W  = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Divide-by-zero: quotient is all ones, remainder passes the dividend through.
   localparam logic DIV0_QUO_BIT = 1'b1;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_iter_step
   import div_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quo_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] rem_next_o,
   output logic [DATA_W-1:0] quo_next_o
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[DATA_W-1]};
      diff    = shifted - {1'b0, divisor_i};
      // A clear top bit means the trial subtraction did not borrow.
      if (!diff[DATA_W]) begin
         rem_next_o = diff[DATA_W-1:0];
         quo_next_o = {quo_i[DATA_W-2:0], 1'b1};
      end else begin
         rem_next_o = shifted[DATA_W-1:0];
         quo_next_o = {quo_i[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_iter_ctrl.sv
// Multi-cycle div.w/mod.w/div.wu/mod.wu unit with request/response handshakes and cancel.
module div_iter_ctrl
   import div_pkg::*;
#(
   parameter int unsigned DATA_W = DIV_DATA_W,
   parameter int unsigned CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_signed,
   input  logic              req_rem,
   input  logic [DATA_W-1:0] req_src1,
   input  logic [DATA_W-1:0] req_src2,
   input  logic              cancel,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   div_state_e        state_q;
   logic [DATA_W-1:0] src1_q, src2_q;
   logic [DATA_W-1:0] dsr_q, rem_q, quo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              signed_q, remsel_q, qneg_q, rneg_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;

   logic [DATA_W-1:0] mag1_d, mag2_d;
   logic [DATA_W-1:0] rem_nxt, quo_nxt;
   logic [DATA_W-1:0] quo_fix_d, rem_fix_d;

   div_iter_step #(.DATA_W(DATA_W)) u_step (
      .rem_i      (rem_q),
      .quo_i      (quo_q),
      .divisor_i  (dsr_q),
      .rem_next_o (rem_nxt),
      .quo_next_o (quo_nxt)
   );

   always_comb begin
      mag1_d    = (signed_q && src1_q[DATA_W-1]) ? ('0 - src1_q) : src1_q;
      mag2_d    = (signed_q && src2_q[DATA_W-1]) ? ('0 - src2_q) : src2_q;
      quo_fix_d = qneg_q ? ('0 - quo_nxt) : quo_nxt;
      rem_fix_d = rneg_q ? ('0 - rem_nxt) : rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         src1_q       <= '0;
         src2_q       <= '0;
         dsr_q        <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         cnt_q        <= '0;
         signed_q     <= 1'b0;
         remsel_q     <= 1'b0;
         qneg_q       <= 1'b0;
         rneg_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else if (cancel) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  src1_q   <= req_src1;
                  src2_q   <= req_src2;
                  signed_q <= req_signed;
                  remsel_q <= req_rem;
                  state_q  <= PREP;
               end
            end
            PREP: begin
               quo_q  <= mag1_d;
               dsr_q  <= mag2_d;
               rem_q  <= '0;
               cnt_q  <= '0;
               qneg_q <= signed_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
               rneg_q <= signed_q & src1_q[DATA_W-1];
               if (src2_q == '0) begin
                  resp_data_q  <= remsel_q ? src1_q : {DATA_W{DIV0_QUO_BIT}};
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end else begin
                  state_q <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               cnt_q <= cnt_q + CNT_W'(1);
               // Final iteration: sign fixup and result select happen on the DONE entry edge.
               if (cnt_q == CNT_LAST) begin
                  resp_data_q  <= remsel_q ? rem_fix_d : quo_fix_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Directed bench for div_iter_ctrl with a latency-level reference model checked every cycle.
module tb_div_iter_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         resetn, req_valid, req_signed, req_rem, cancel, resp_ready;
   logic [W-1:0] req_src1, req_src2;
   logic         req_ready, resp_valid, busy;
   logic [W-1:0] resp_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // Reference model: pending result, cycles remaining until it appears, handshake state.
   bit         m_busy  = 1'b0;
   bit         m_valid = 1'b0;
   int         m_left  = 0;
   logic [W-1:0] m_res  = '0;
   logic [W-1:0] m_data = '0;

   always #5 clk = ~clk;

   div_iter_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_signed (req_signed),
      .req_rem    (req_rem),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .cancel     (cancel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // LoongArch division semantics computed on 64-bit magnitudes so INT_MIN/-1 is safe.
   function automatic logic [W-1:0] ref_div(input bit sg, input bit rm,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
      longint ma, mb, q, r;
      if (b == '0) return rm ? a : 32'hFFFF_FFFF;
      ma = (sg && a[W-1]) ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
      mb = (sg && b[W-1]) ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
      q  = ma / mb;
      r  = ma % mb;
      if (sg && (a[W-1] ^ b[W-1])) q = -q;
      if (sg && a[W-1]) r = -r;
      return rm ? r[W-1:0] : q[W-1:0];
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!resetn) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_data  = '0;
      end else if (cancel) begin
         m_busy  = 1'b0;
         m_valid = 1'b0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy = 1'b1;
            m_left = (req_src2 == '0) ? 1 : 33;
            m_res  = ref_div(req_signed, req_rem, req_src1, req_src2);
         end
      end else if (!m_valid) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            m_data  = m_res;
         end
      end else if (resp_ready) begin
         m_valid = 1'b0;
         m_busy  = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model req_ready", W'(req_ready), W'(!m_busy));
         check("model busy", W'(busy), W'(m_busy));
         check("model resp_valid", W'(resp_valid), W'(m_valid));
         if (m_valid) check("model resp_data", resp_data, m_data);
      end
   end

   task automatic run_op(input string name, input bit sg, input bit rm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat, input int hold);
      int n;
      bit got;
      check({name, " ready"}, W'(req_ready), W'(1));
      req_valid  = 1'b1;
      req_signed = sg;
      req_rem    = rm;
      req_src1   = a;
      req_src2   = b;
      n = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (resp_valid) got = 1'b1;
         else @(negedge clk);
      end
      check({name, " resp seen"}, W'(got), W'(1));
      check({name, " latency"}, W'(cyc - n), W'(exp_lat));
      check({name, " data"}, resp_data, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, " hold data"}, resp_data, exp);
         check({name, " hold busy"}, W'(busy), W'(1));
         check({name, " hold ready"}, W'(req_ready), W'(0));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({name, " idle ready"}, W'(req_ready), W'(1));
      check({name, " idle valid"}, W'(resp_valid), W'(0));
   endtask

   initial begin
      int n, seen;
      resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_rem = 1'b0;
      req_src1 = '0; req_src2 = '0; cancel = 1'b0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      chk_en = 1'b1;
      check("reset data", resp_data, '0);
      check("reset ready", W'(req_ready), W'(1));
      check("reset busy", W'(busy), W'(0));

      run_op("u100/7 q", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34, 0);
      run_op("u100/7 r", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 34, 0);
      run_op("s-7/2 q", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
      run_op("s-7/2 r", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
      run_op("s7/-2 q", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
      run_op("s7/-2 r", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
      run_op("ovf q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
      run_op("ovf r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);
      run_op("uffff/1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
      run_op("u5/0 q", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
      run_op("u5/0 r", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 2, 0);

      // Cancel during CALC.
      req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0;
      req_src1 = 32'd100; req_src2 = 32'd7;
      n = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      while (cyc < n + 10) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel ready", W'(req_ready), W'(1));
      check("cancel busy", W'(busy), W'(0));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("cancel no resp", W'(seen), W'(0));
      run_op("u9/3 after cancel", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 34, 0);

      run_op("stall 5", 1'b0, 1'b0, 32'd1000, 32'd10, 32'd100, 34, 5);

      // Cancel alongside a request: not accepted.
      req_valid = 1'b1; cancel = 1'b1; req_src1 = 32'd9; req_src2 = 32'd3;
      @(negedge clk);
      req_valid = 1'b0; cancel = 1'b0;
      check("cancel+req busy", W'(busy), W'(0));
      check("cancel+req ready", W'(req_ready), W'(1));
      repeat (36) @(negedge clk);
      check("cancel+req no resp", W'(resp_valid), W'(0));

      // Cancel in DONE together with resp_ready.
      req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0;
      req_src1 = 32'd5; req_src2 = 32'd0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("done cancel valid pre", W'(resp_valid), W'(1));
      cancel = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      cancel = 1'b0; resp_ready = 1'b0;
      check("done cancel valid", W'(resp_valid), W'(0));
      check("done cancel ready", W'(req_ready), W'(1));

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
